// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM state type and default parameters for the FIR filter.
package fir_pkg;
   localparam int DATA_W_DEF     = 16;
   localparam int TAPS_DEF       = 4;
   localparam int SAMPLE_CNT_DEF = 1000;
   typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_t;
endpackage

// File: rtl/fir_mac.sv
// fir_mac: signed multiply-accumulate with synchronous clear and enable.
module fir_mac #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 34
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [ACC_W-1:0]  acc
);
   logic signed [2*DATA_W-1:0] prod;
   assign prod = a * b;
   always_ff @(posedge clk) begin
      if (reset || clr) acc <= '0;
      else if (en) acc <= acc + ACC_W'(prod);
   end
endmodule

// File: rtl/fir_filter_param.sv
// fir_filter_param: strobe-driven TAPS-tap FIR, one tap per cycle, saturated magnitude output.
module fir_filter_param
   import fir_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int TAPS       = TAPS_DEF,
   parameter int SAMPLE_CNT = SAMPLE_CNT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] sample_data,
   input  logic [DATA_W-1:0] fir_coefficient,
   input  logic              data_ready,
   input  logic              load_coeff,
   output logic              modwait,
   output logic [DATA_W-1:0] fir_out,
   output logic              err,
   output logic              coeff_valid,
   output logic              count_done
);
   localparam int IDX_W = $clog2(TAPS);
   localparam int ACC_W = 2*DATA_W + $clog2(TAPS);
   localparam int CNT_W = $clog2(SAMPLE_CNT + 1);
   localparam logic signed [ACC_W-1:0] R_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] R_MIN = ~R_MAX;
   localparam logic [DATA_W-1:0] O_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] O_MIN = ~O_MAX;

   fir_state_t state, next_state;
   logic data_prev, load_prev;
   logic [IDX_W-1:0] load_idx, tap_idx;
   logic [CNT_W-1:0] cnt;
   logic signed [DATA_W-1:0] coef [TAPS];
   logic signed [DATA_W-1:0] samp [TAPS];
   logic signed [ACC_W-1:0] acc, r;
   logic [DATA_W-1:0] r_sat, mag;
   logic data_edge, load_edge, idle, accept, last_tap, last_load, cnt_wrap, sat_hi, sat_lo, bad_edge;

   assign data_edge = data_ready & ~data_prev;
   assign load_edge = load_coeff & ~load_prev;
   assign idle      = state == IDLE;
   // a coefficient edge in the same cycle wins; the sample is dropped
   assign accept    = idle & data_edge & ~load_edge & coeff_valid;
   assign bad_edge  = idle ? data_edge & (load_edge | ~coeff_valid) : data_edge | load_edge;
   assign last_tap  = tap_idx == IDX_W'(TAPS-1);
   assign last_load = load_idx == IDX_W'(TAPS-1);
   assign cnt_wrap  = cnt == CNT_W'(SAMPLE_CNT-1);

   assign r      = acc >>> (DATA_W-1);
   assign sat_hi = r > R_MAX;
   assign sat_lo = r < R_MIN;
   assign r_sat  = sat_hi ? O_MAX : sat_lo ? O_MIN : r[DATA_W-1:0];
   assign mag    = (r_sat == O_MIN) ? O_MAX : r_sat[DATA_W-1] ? -r_sat : r_sat;

   fir_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
      .clk(clk), .reset(reset), .clr(accept), .en(state == MAC),
      .a(samp[tap_idx]), .b(coef[tap_idx]), .acc(acc)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= next_state;
   end

   always_comb begin
      next_state = state;
      next_state = (state == IDLE) ? (accept ? MAC : IDLE) :
                   (state == MAC)  ? (last_tap ? OUT : MAC) : IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TAPS; i++) begin
            coef[i] <= '0;
            samp[i] <= '0;
         end
      end else begin
         if (idle && load_edge) coef[load_idx] <= fir_coefficient;
         if (accept) begin
            samp[0] <= sample_data;
            for (int i = 1; i < TAPS; i++) samp[i] <= samp[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_prev   <= 1'b0;
         load_prev   <= 1'b0;
         load_idx    <= '0;
         tap_idx     <= '0;
         cnt         <= '0;
         modwait     <= 1'b0;
         fir_out     <= '0;
         err         <= 1'b0;
         coeff_valid <= 1'b0;
         count_done  <= 1'b0;
      end else begin
         data_prev  <= data_ready;
         load_prev  <= load_coeff;
         modwait    <= next_state != IDLE;
         count_done <= accept & cnt_wrap;
         tap_idx    <= (state == MAC && !last_tap) ? tap_idx + 1'b1 : '0;
         if (idle && load_edge) begin
            load_idx <= last_load ? '0 : load_idx + 1'b1;
            if (last_load) coeff_valid <= 1'b1;
         end
         if (accept) cnt <= cnt_wrap ? '0 : cnt + 1'b1;
         if (state == OUT) fir_out <= mag;
         err <= accept ? 1'b0 : (bad_edge || (state == OUT && (sat_hi || sat_lo))) ? 1'b1 : err;
      end
   end
endmodule

// File: tb/tb_fir_filter_param.sv
// tb_fir_filter_param: directed checks of the FIR filter with TAPS=4, SAMPLE_CNT=4.
module tb_fir_filter_param;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] sample_data = '0;
   logic [15:0] fir_coefficient = '0;
   logic        data_ready = 1'b0;
   logic        load_coeff = 1'b0;
   logic        modwait, err, coeff_valid, count_done;
   logic [15:0] fir_out;
   int n_cmp = 0;
   int n_bad = 0;

   fir_filter_param #(.DATA_W(16), .TAPS(4), .SAMPLE_CNT(4)) dut (
      .clk(clk), .reset(reset), .sample_data(sample_data), .fir_coefficient(fir_coefficient),
      .data_ready(data_ready), .load_coeff(load_coeff), .modwait(modwait), .fir_out(fir_out),
      .err(err), .coeff_valid(coeff_valid), .count_done(count_done)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
   endtask

   task automatic load_one(input logic [15:0] c);
      @(negedge clk) fir_coefficient = c; load_coeff = 1'b1;
      @(negedge clk) load_coeff = 1'b0;
   endtask

   task automatic load4(input logic [15:0] c);
      for (int i = 0; i < 4; i++) load_one(c);
   endtask

   task automatic send(input logic [15:0] v, output int mw, output logic cd1, output logic cd_rest, output logic err1);
      @(negedge clk) sample_data = v; data_ready = 1'b1;
      @(negedge clk) data_ready = 1'b0;
      cd1 = count_done; err1 = err; cd_rest = 1'b0; mw = 0;
      for (int i = 0; i < 8; i++) begin
         if (modwait) mw++;
         if (i > 0 && count_done) cd_rest = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp += 5;
      if (modwait !== 1'b0) begin n_bad++; $display("FAIL reset_modwait: got %b want 0", modwait); end
      if (fir_out !== 16'd0) begin n_bad++; $display("FAIL reset_fir_out: got %0d want 0", fir_out); end
      if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
      if (coeff_valid !== 1'b0) begin n_bad++; $display("FAIL reset_coeff_valid: got %b want 0", coeff_valid); end
      if (count_done !== 1'b0) begin n_bad++; $display("FAIL reset_count_done: got %b want 0", count_done); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      logic [15:0] smp [4] = '{16'd100, 16'd200, 16'd300, 16'd400};
      logic [15:0] exp [4] = '{16'd50, 16'd150, 16'd300, 16'd500};
      int mw; logic cd1, cdr, e1;
      do_reset();
      for (int i = 0; i < 3; i++) load_one(16'h4000);
      n_cmp++;
      if (coeff_valid !== 1'b0) begin n_bad++; $display("FAIL basic_cv_partial: got %b want 0", coeff_valid); end
      load_one(16'h4000);
      n_cmp++;
      if (coeff_valid !== 1'b1) begin n_bad++; $display("FAIL basic_cv_full: got %b want 1", coeff_valid); end
      for (int i = 0; i < 4; i++) begin
         send(smp[i], mw, cd1, cdr, e1);
         n_cmp += 3;
         if (fir_out !== exp[i]) begin n_bad++; $display("FAIL basic_out[%0d]: got %0d want %0d", i, fir_out, exp[i]); end
         if (mw !== 5) begin n_bad++; $display("FAIL basic_modwait[%0d]: got %0d cycles want 5", i, mw); end
         if (err !== 1'b0) begin n_bad++; $display("FAIL basic_err[%0d]: got %b want 0", i, err); end
      end
   endtask

   task automatic test_negative();
      int mw; logic cd1, cdr, e1;
      do_reset();
      load_one(16'h4000); load_one(16'h0000); load_one(16'h0000); load_one(16'h0000);
      send(16'hFF38, mw, cd1, cdr, e1);
      n_cmp++;
      if (fir_out !== 16'd100) begin n_bad++; $display("FAIL neg_out: got %0d want 100", fir_out); end
   endtask

   task automatic test_saturate();
      int mw; logic cd1, cdr, e1;
      do_reset();
      load4(16'h7FFF);
      send(16'h7FFF, mw, cd1, cdr, e1);
      n_cmp += 2;
      if (fir_out !== 16'd32766) begin n_bad++; $display("FAIL sat_first_out: got %0d want 32766", fir_out); end
      if (err !== 1'b0) begin n_bad++; $display("FAIL sat_first_err: got %b want 0", err); end
      for (int i = 0; i < 3; i++) send(16'h7FFF, mw, cd1, cdr, e1);
      n_cmp += 2;
      if (fir_out !== 16'h7FFF) begin n_bad++; $display("FAIL sat_out: got %h want 7fff", fir_out); end
      if (err !== 1'b1) begin n_bad++; $display("FAIL sat_err: got %b want 1", err); end
      send(16'h7FFF, mw, cd1, cdr, e1);
      n_cmp += 2;
      if (e1 !== 1'b0) begin n_bad++; $display("FAIL sat_err_clear: got %b want 0", e1); end
      if (err !== 1'b1) begin n_bad++; $display("FAIL sat_err_again: got %b want 1", err); end
   endtask

   task automatic test_drop();
      int mw; logic cd1, cdr, e1;
      do_reset();
      load4(16'h4000);
      @(negedge clk) sample_data = 16'd100; data_ready = 1'b1;
      @(negedge clk) data_ready = 1'b0;
      @(negedge clk) sample_data = 16'd999; data_ready = 1'b1;
      @(negedge clk) data_ready = 1'b0;
      repeat (6) @(negedge clk);
      n_cmp += 2;
      if (fir_out !== 16'd50) begin n_bad++; $display("FAIL drop_out: got %0d want 50", fir_out); end
      if (err !== 1'b1) begin n_bad++; $display("FAIL drop_err: got %b want 1", err); end
      send(16'd200, mw, cd1, cdr, e1);
      n_cmp += 2;
      if (fir_out !== 16'd150) begin n_bad++; $display("FAIL drop_next_out: got %0d want 150", fir_out); end
      if (e1 !== 1'b0) begin n_bad++; $display("FAIL drop_err_clear: got %b want 0", e1); end
      do_reset();
      @(negedge clk) sample_data = 16'd5; data_ready = 1'b1;
      @(negedge clk) data_ready = 1'b0;
      n_cmp += 2;
      if (err !== 1'b1) begin n_bad++; $display("FAIL nocoef_err: got %b want 1", err); end
      if (modwait !== 1'b0) begin n_bad++; $display("FAIL nocoef_modwait: got %b want 0", modwait); end
   endtask

   task automatic test_simultaneous();
      int mw; logic cd1, cdr, e1;
      do_reset();
      load4(16'h4000);
      @(negedge clk) fir_coefficient = 16'h2000; load_coeff = 1'b1; sample_data = 16'd999; data_ready = 1'b1;
      @(negedge clk) load_coeff = 1'b0; data_ready = 1'b0;
      n_cmp += 2;
      if (err !== 1'b1) begin n_bad++; $display("FAIL simul_err: got %b want 1", err); end
      if (modwait !== 1'b0) begin n_bad++; $display("FAIL simul_modwait: got %b want 0", modwait); end
      send(16'd400, mw, cd1, cdr, e1);
      n_cmp++;
      if (fir_out !== 16'd100) begin n_bad++; $display("FAIL simul_out: got %0d want 100", fir_out); end
   endtask

   task automatic test_load_busy();
      int mw; logic cd1, cdr, e1;
      do_reset();
      load4(16'h4000);
      @(negedge clk) sample_data = 16'd100; data_ready = 1'b1;
      @(negedge clk) data_ready = 1'b0;
      @(negedge clk) fir_coefficient = 16'h0000; load_coeff = 1'b1;
      @(negedge clk) load_coeff = 1'b0;
      repeat (6) @(negedge clk);
      n_cmp += 2;
      if (fir_out !== 16'd50) begin n_bad++; $display("FAIL busy_out: got %0d want 50", fir_out); end
      if (err !== 1'b1) begin n_bad++; $display("FAIL busy_err: got %b want 1", err); end
      send(16'd100, mw, cd1, cdr, e1);
      n_cmp++;
      if (fir_out !== 16'd100) begin n_bad++; $display("FAIL busy_next_out: got %0d want 100", fir_out); end
   endtask

   task automatic test_count();
      int mw; logic cd1, cdr, e1;
      do_reset();
      load4(16'h4000);
      for (int k = 1; k <= 9; k++) begin
         send(16'(k * 10), mw, cd1, cdr, e1);
         n_cmp += 2;
         if (cd1 !== (k == 4 || k == 8)) begin n_bad++; $display("FAIL count_pulse[%0d]: got %b want %b", k, cd1, (k == 4 || k == 8)); end
         if (cdr !== 1'b0) begin n_bad++; $display("FAIL count_extra[%0d]: got %b want 0", k, cdr); end
      end
   endtask

   task automatic test_reset_mid();
      int mw; logic cd1, cdr, e1; logic bad_hold = 1'b0;
      do_reset();
      load4(16'h4000);
      send(16'd100, mw, cd1, cdr, e1);
      n_cmp++;
      if (fir_out !== 16'd50) begin n_bad++; $display("FAIL rmid_pre_out: got %0d want 50", fir_out); end
      @(negedge clk) sample_data = 16'd200; data_ready = 1'b1;
      @(negedge clk) data_ready = 1'b0;
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      n_cmp += 5;
      if (modwait !== 1'b0) begin n_bad++; $display("FAIL rmid_modwait: got %b want 0", modwait); end
      if (fir_out !== 16'd0) begin n_bad++; $display("FAIL rmid_fir_out: got %0d want 0", fir_out); end
      if (err !== 1'b0) begin n_bad++; $display("FAIL rmid_err: got %b want 0", err); end
      if (coeff_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_coeff_valid: got %b want 0", coeff_valid); end
      if (count_done !== 1'b0) begin n_bad++; $display("FAIL rmid_count_done: got %b want 0", count_done); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (fir_out !== 16'd0 || modwait !== 1'b0) bad_hold = 1'b1;
      end
      n_cmp++;
      if (bad_hold !== 1'b0) begin n_bad++; $display("FAIL rmid_hold: got %b want 0 (fir_out %0d)", bad_hold, fir_out); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negative();
      test_saturate();
      test_drop();
      test_simultaneous();
      test_load_busy();
      test_count();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
